// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer and its 1-bit slice.
package alu_pkg;

    // Slice result select, the low two bits of a function code.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    // Full function codes {A_invert, B_invert, op[1:0]}.
    localparam logic [3:0] FUNC_AND = 4'b0000;
    localparam logic [3:0] FUNC_OR  = 4'b0001;
    localparam logic [3:0] FUNC_ADD = 4'b0010;
    localparam logic [3:0] FUNC_SUB = 4'b0110;
    localparam logic [3:0] FUNC_SLT = 4'b0111;
    localparam logic [3:0] FUNC_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_serial_ctrl_alu.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add, and a
// Less input for set-on-less-than chaining.
module ALU
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carry_in_i,
    input  logic       a_invert_i,
    input  logic       b_invert_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       result_o,
    output logic       carry_out_o,
    output logic       set_o,
    output logic       overflow_o
);

    logic a_eff;
    logic b_eff;
    logic sum;

    // Combinational slice: invert, add, and select the result for this bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        result_o    = 1'b0;
        a_eff       = a_i ^ a_invert_i;
        b_eff       = b_i ^ b_invert_i;
        sum         = a_eff ^ b_eff ^ carry_in_i;
        carry_out_o = (a_eff & b_eff) | (a_eff & carry_in_i) | (b_eff & carry_in_i);
        set_o       = sum;
        overflow_o  = carry_in_i ^ carry_out_o;
        case (op_i)
            OP_AND:  result_o = a_eff & b_eff;
            OP_OR:   result_o = a_eff | b_eff;
            OP_ADD:  result_o = sum;
            // With Less tied low this path exposes the raw sum bit.
            default: result_o = sum | less_i;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: steps one 1-bit ALU slice across WIDTH bit
// positions, LSB first, and registers the result and status flags.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       func,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds bits [WIDTH-2:0]; the MSB comes straight from the slice.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic [3:0]       func_q, func_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             slice_res;
    logic             slice_cout;
    logic             msb_cin;
    logic             msb_sum;

    // Only meaningful on the MSB pass: carry into the MSB and its sum bit.
    assign msb_cin = carry_q;
    assign msb_sum = slice_res;

    ALU u_slice (
        .a_i         (a_sh_q[0]),
        .b_i         (b_sh_q[0]),
        .carry_in_i  (carry_q),
        .a_invert_i  (func_q[3]),
        .b_invert_i  (func_q[2]),
        .less_i      (1'b0),
        .op_i        (func_q[1:0]),
        .result_o    (slice_res),
        .carry_out_o (slice_cout),
        .set_o       (),
        .overflow_o  ()
    );

    // Next-state logic: accept, step one bit per cycle, resolve on the MSB pass.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        func_d      = func_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    func_d  = func;
                    cnt_d   = '0;
                    carry_d = func[2];
                end
            end
            S_RUN: begin
                res_sh_d             = res_sh_q >> 1;
                res_sh_d[WIDTH-2]    = slice_res;
                a_sh_d               = a_sh_q >> 1;
                b_sh_d               = b_sh_q >> 1;
                carry_d              = slice_cout;
                if (cnt_q == LAST_BIT) begin
                    // Outputs load on entry to DONE so they are valid with done.
                    state_d = S_DONE;
                    if (func_q[1:0] == OP_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}}, msb_sum ^ (msb_cin ^ slice_cout)};
                    end else begin
                        result_d = {slice_res, res_sh_q};
                    end
                    carry_out_d = (func_q[1:0] == OP_ADD) & slice_cout;
                    overflow_d  = func_q[1] & (msb_cin ^ slice_cout);
                    zero_d      = (result_d == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            func_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            func_q      <= func_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [3:0]   func;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: cycles elapsed since acceptance (0 = idle).
    int           m_cnt   = 0;
    bit           armed   = 1'b0;
    int           cyc     = 0;
    int           done_seen = 0;
    logic [3:0]   m_f;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    exp_t         exp_q   = '{res: '0, c: 1'b0, v: 1'b0, z: 1'b1};

    logic [W-1:0] last_res      = '0;
    int           last_done_cyc = 0;
    bit           chained       = 1'b0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .func      (func),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Whole-word arithmetic view of what a function code must produce.
    function automatic exp_t ref_alu(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   full;
        logic [W-1:0] low;
        logic         cin_msb;
        logic         cout;
        logic         ovf;
        x       = f[3] ? ~a : a;
        y       = f[2] ? ~b : b;
        full    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, f[2]};
        low     = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, f[2]};
        cin_msb = low[W-1];
        cout    = full[W];
        ovf     = cin_msb ^ cout;
        case (f[1:0])
            2'b00:   e.res = x & y;
            2'b01:   e.res = x | y;
            2'b10:   e.res = full[W-1:0];
            default: e.res = {{(W-1){1'b0}}, full[W-1] ^ ovf};
        endcase
        e.c = (f[1:0] == 2'b10) & cout;
        e.v = f[1] & ovf;
        e.z = (e.res == '0);
        return e;
    endfunction

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            armed <= 1'b1;
            m_cnt <= 0;
            exp_q <= '{res: '0, c: 1'b0, v: 1'b0, z: 1'b1};
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt <= 1;
                m_f   <= func;
                m_a   <= a_in;
                m_b   <= b_in;
            end
        end else if (m_cnt == W + 1) begin
            m_cnt <= 0;
        end else begin
            if (m_cnt == W) exp_q <= ref_alu(m_f, m_a, m_b);
            m_cnt <= m_cnt + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("done", 32'(done), 32'(m_cnt == W + 1));
            check("result", 32'(result), 32'(exp_q.res));
            check("carry_out", 32'(carry_out), 32'(exp_q.c));
            check("overflow", 32'(overflow), 32'(exp_q.v));
            check("zero", 32'(zero), 32'(exp_q.z));
            if (done === 1'b1) done_seen <= done_seen + 1;
        end
    end

    task automatic run_op(input string name, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er,
                          input logic ec, input logic ev, input logic ez);
        int lat;
        bit got;
        @(posedge clk); #1;
        start = 1'b1;
        func  = f;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        func  = 4'($urandom);
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({name, " held"}, 32'(result), 32'(last_res));
            if (done === 1'b1) got = 1'b1;
        end
        check({name, " latency"}, lat, W + 1);
        if (got) begin
            check({name, " result"}, 32'(result), 32'(er));
            check({name, " carry_out"}, 32'(carry_out), 32'(ec));
            check({name, " overflow"}, 32'(overflow), 32'(ev));
            check({name, " zero"}, 32'(zero), 32'(ez));
            if (chained) check({name, " spacing"}, cyc - last_done_cyc, W + 2);
        end
        last_res      = er;
        last_done_cyc = cyc;
        chained       = 1'b1;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        func  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset zero", 32'(zero), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Arithmetic, chained back-to-back.
        run_op("add_ovf",  FUNC_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_zero", FUNC_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("slt_neg",  FUNC_SLT, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf0", FUNC_SLT, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
        run_op("slt_ovf1", FUNC_SLT, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap", FUNC_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_neg",  FUNC_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op("inv_add",  4'b1110,  8'h10, 8'h20, 8'hCF, 1'b1, 1'b0, 1'b0);

        // Logic ops.
        run_op("and", FUNC_AND, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0);
        run_op("or",  FUNC_OR,  8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0);
        run_op("nor", FUNC_NOR, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1);

        // Starts during RUN (cycle 3) and during DONE (cycle 9) are ignored.
        @(posedge clk); #1;
        base  = done_seen;
        start = 1'b1;
        func  = FUNC_ADD;
        a_in  = 8'h12;
        b_in  = 8'h34;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            start = (c == 2 || c == 8);
        end
        @(negedge clk);
        check("ignored_start done count", done_seen - base, 1);
        check("ignored_start result", 32'(result), 32'h46);
        check("ignored_start idle", 32'(busy), 32'd0);

        // Reset during RUN cycle 4 wins over a simultaneous start.
        @(posedge clk); #1;
        base  = done_seen;
        start = 1'b1;
        func  = FUNC_OR;
        a_in  = 8'h0F;
        b_in  = 8'h30;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("mid_run busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("after_reset busy", 32'(busy), 32'd0);
        check("after_reset result", 32'(result), 32'd0);
        check("after_reset zero", 32'(zero), 32'd1);
        repeat (15) @(negedge clk);
        check("after_reset no done", done_seen - base, 0);

        // Recovery after reset.
        last_res = '0;
        chained  = 1'b0;
        run_op("post_reset_add", FUNC_ADD, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
